mdu_rv32m: RTL and testbench
============================

# mdu_rv32m

Iterative RV32M multiply/divide unit between register-file read and register-file write-back. It captures two source operands read from the register file, then computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 cycles. It returns the result through a one-cycle write port that connects directly to the register file's write address, data and enable inputs.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- CLK  in  1  rising-edge clock, shared with the register file.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; accepted only on a rising edge where state is IDLE.
- FUNCT3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SRC_A  in  32  rs1 value (register-file RD1).
- SRC_B  in  32  rs2 value (register-file RD2).
- RD_IN  in  5  destination register index.
- BUSY  out  1  high in RUN and DONE; the unit ignores START while high.
- DONE  out  1  one-cycle completion pulse.
- A3_OUT  out  5  captured RD_IN; drives register-file A3.
- RESULT  out  32  result; drives register-file WD3; held stable until the next accept.
- WE_OUT  out  1  equals DONE && (A3_OUT != 0); drives register-file WE.

## Operation
- States:
  - IDLE -> RUN on START (normal case).
  - IDLE -> DONE on START (special cases).
  - RUN -> DONE after 32 iterations.
  - DONE -> IDLE unconditionally.
- Accept:
  - SRC_A, SRC_B, FUNCT3 and RD_IN are registered.
  - Later changes on these inputs have no effect.
- Signedness:
  - Signed operands are converted to magnitudes at accept; the result sign is recorded.
  - MULH: both operands signed. MULHSU: SRC_A signed, SRC_B unsigned. DIV/REM: both signed.
- Multiply:
  - Radix-2 shift-add with a 64-bit product register and a 6-bit iteration counter 0..31.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
  - Sign correction is a 64-bit two's-complement negate applied before the slice.
- Divide:
  - Restoring, one quotient bit per iteration, with a 33-bit partial remainder.
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A).
- Special cases, decided at accept and skipping RUN:
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> SRC_A.
  - Signed overflow (SRC_A=0x80000000, SRC_B=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0x00000000.
- Write to x0: DONE still pulses and RESULT is valid, but WE_OUT stays 0.
- Reset:
  - RST forces IDLE and zeros all outputs.
  - Reset during RUN or DONE aborts the operation; no WE_OUT pulse occurs for it.
  - RST has priority over START on the same edge.

## Timing
- Reset values: BUSY=0, DONE=0, WE_OUT=0, A3_OUT=0, RESULT=0; counter 0.
- Let E0 be the accepting edge.
  - BUSY is high from E0.
  - Normal ops: iterations on E0+1..E0+32; DONE is high for the single cycle E0+32..E0+33.
  - Special cases: DONE is high for the single cycle E0..E0+1.
- RESULT and A3_OUT become valid with DONE and hold until the next accept.
- All outputs are registered, with no combinational path from inputs to outputs. WE_OUT is derived from the registered DONE and A3_OUT.
- The register file writes RESULT on the edge that ends the DONE cycle.
- BUSY drops at that same edge. The earliest next accept is therefore that edge plus one, giving a back-to-back period of 34 cycles for normal ops.
- START asserted while BUSY is dropped and not queued.

## Structure
- Shared package mdu_pkg holds:
  - FUNCT3 localparams: F3_MUL .. F3_REMU.
  - State encoding: S_IDLE, S_RUN, S_DONE (2 bits).
  - The iteration count constant N_ITER=32.
- One module holds the FSM, the counter and the shared datapath (product/remainder register, operand register, sign flags).
- A negate helper mdu_neg is a natural sub-module; it is instantiated for operand magnitude conversion and for result correction.

## Test plan
- MUL: A=7, B=6, RD_IN=5 -> DONE at E0+32; RESULT=42; A3_OUT=5; WE_OUT=1 for exactly one cycle; BUSY low one edge later.
- Signed high products, A=0xFFFFFFFF, B=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
  - MUL -> 0x00000001.
- Division, A=-7 (0xFFFFFFF9), B=2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU -> 0x7FFFFFFC.
  - REMU -> 1.
- Special cases:
  - DIVU A=123, B=0 -> 0xFFFFFFFF, with DONE at E0 (one cycle).
  - REM A=0x80000000, B=0xFFFFFFFF -> 0.
  - DIV with the same operands -> 0x80000000.
- x0 and START-while-busy:
  - RD_IN=0 -> DONE=1, WE_OUT=0.
  - A second START pulsed while BUSY -> ignored; exactly one DONE.
  - A START in the cycle after BUSY falls -> accepted.
- Reset abort: assert RST at E0+10 of a DIV -> all outputs 0 next cycle; no DONE/WE_OUT pulse; a new op then completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and the iteration count.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [5:0] N_ITER = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mdu_rv32m_if.sv
// Request/result bundle between the register file read stage, the MDU and
// the register file write port.
interface mdu_rv32m_if;

  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [4:0]  a3_out;
  logic [31:0] result;
  logic        we_out;

  modport master (
    output start, funct3, src_a, src_b, rd_in,
    input  busy, done, a3_out, result, we_out
  );

  modport slave (
    input  start, funct3, src_a, src_b, rd_in,
    output busy, done, a3_out, result, we_out
  );

endinterface

// File: rtl/mdu_neg.sv
// Two's-complement negate, shared by operand magnitude conversion and
// result sign correction.
module mdu_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/mdu_rv32m.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over 32 cycles, result delivered on a one-cycle write port.
module mdu_rv32m
  import mdu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mdu_rv32m_if.slave bus
);

  state_t      state_r, state_s;
  logic [5:0]  cnt_r, cnt_s;
  logic [63:0] acc_r, acc_s;
  logic [31:0] opb_r, opb_s;
  logic [2:0]  f3_r, f3_s;
  logic [4:0]  rd_r, rd_s;
  logic        neg_r, neg_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        we_r, we_s;
  logic [4:0]  a3_r, a3_s;
  logic [31:0] result_r, result_s;

  logic        signed_a_s, signed_b_s, sign_a_s, sign_b_s;
  logic [31:0] neg_a_s, neg_b_s, mag_a_s, mag_b_s;
  logic        div_zero_s, div_ovf_s;
  logic [31:0] special_res_s;

  assign signed_a_s = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
                      (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
  assign signed_b_s = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) ||
                      (bus.funct3 == F3_REM);
  assign sign_a_s   = signed_a_s & bus.src_a[31];
  assign sign_b_s   = signed_b_s & bus.src_b[31];

  mdu_neg #(.WIDTH(32)) u_neg_a (.a(bus.src_a), .y(neg_a_s));
  mdu_neg #(.WIDTH(32)) u_neg_b (.a(bus.src_b), .y(neg_b_s));

  assign mag_a_s = sign_a_s ? neg_a_s : bus.src_a;
  assign mag_b_s = sign_b_s ? neg_b_s : bus.src_b;

  // Divide-by-zero and signed overflow finish at accept without iterating
  assign div_zero_s = bus.funct3[2] && (bus.src_b == 32'h0000_0000);
  assign div_ovf_s  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                      (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF);
  assign special_res_s = div_zero_s ? (bus.funct3[1] ? bus.src_a : 32'hFFFF_FFFF)
                                    : (bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000);

  logic [32:0] mul_sum_s;
  logic        div_ge_s;
  logic [31:0] div_diff_s;
  logic [63:0] step_s;

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}
  assign mul_sum_s  = {1'b0, acc_r[63:32]} + {1'b0, opb_r};
  assign div_ge_s   = acc_r[63:31] >= {1'b0, opb_r};
  assign div_diff_s = acc_r[62:31] - opb_r;
  assign step_s = f3_r[2]
                ? (div_ge_s ? {div_diff_s, acc_r[30:0], 1'b1} : {acc_r[62:0], 1'b0})
                : (acc_r[0] ? {mul_sum_s, acc_r[31:1]} : {1'b0, acc_r[63:1]});

  logic [63:0] corr_in_s, corr_neg_s, corr_s;
  logic [31:0] final_s;

  assign corr_in_s = !f3_r[2] ? step_s
                   : (f3_r[1] ? {32'h0000_0000, step_s[63:32]} : {32'h0000_0000, step_s[31:0]});

  mdu_neg #(.WIDTH(64)) u_neg_res (.a(corr_in_s), .y(corr_neg_s));

  assign corr_s  = neg_r ? corr_neg_s : corr_in_s;
  assign final_s = (f3_r[2] || (f3_r == F3_MUL)) ? corr_s[31:0] : corr_s[63:32];

  // Next-state, datapath and output-register logic
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    acc_s    = acc_r;
    opb_s    = opb_r;
    f3_s     = f3_r;
    rd_s     = rd_r;
    neg_s    = neg_r;
    a3_s     = a3_r;
    result_s = result_r;
    done_s   = 1'b0;
    we_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          f3_s  = bus.funct3;
          rd_s  = bus.rd_in;
          opb_s = mag_b_s;
          acc_s = {32'h0000_0000, mag_a_s};
          cnt_s = 6'd0;
          neg_s = (bus.funct3[2] && bus.funct3[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
          if (div_zero_s || div_ovf_s) begin
            state_s  = S_DONE;
            result_s = special_res_s;
            a3_s     = bus.rd_in;
            done_s   = 1'b1;
            we_s     = (bus.rd_in != 5'd0);
          end else begin
            state_s  = S_RUN;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        acc_s = step_s;
        cnt_s = cnt_r + 6'd1;
        if (cnt_r == (N_ITER - 6'd1)) begin
          state_s  = S_DONE;
          result_s = final_s;
          a3_s     = rd_r;
          done_s   = 1'b1;
          we_s     = (rd_r != 5'd0);
        end else begin
          state_s  = S_RUN;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= 6'd0;
      acc_r    <= 64'h0;
      opb_r    <= 32'h0;
      f3_r     <= 3'b000;
      rd_r     <= 5'd0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      we_r     <= 1'b0;
      a3_r     <= 5'd0;
      result_r <= 32'h0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      acc_r    <= acc_s;
      opb_r    <= opb_s;
      f3_r     <= f3_s;
      rd_r     <= rd_s;
      neg_r    <= neg_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      we_r     <= we_s;
      a3_r     <= a3_s;
      result_r <= result_s;
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.we_out = we_r;
  assign bus.a3_out = a3_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_mdu_rv32m.sv
// Directed scoreboard bench for mdu_rv32m: latency, results, write enable,
// special cases, START-while-busy and reset abort.
module tb_mdu_rv32m;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  mdu_rv32m_if bus ();

  mdu_rv32m dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request at the current negedge, returns at the negedge where BUSY has dropped
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                        input bit special, input bit poke);
    exp_t e;
    int   lat;
    e.res = exp_res;
    e.rd  = rd;
    e.we  = (rd != 5'd0);
    sb_q.push_back(e);
    bus.start = 1'b1; bus.funct3 = f3; bus.src_a = a; bus.src_b = b; bus.rd_in = rd;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.src_a  = $urandom;
    bus.src_b  = $urandom;
    bus.rd_in  = 5'($urandom);
    check({tag, " busy_at_e0"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      bus.start = (poke && lat == 5) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(lat), special ? 32'd0 : 32'd32);
    e = sb_q.pop_front();
    check({tag, " result"}, bus.result, e.res);
    check({tag, " a3"}, 32'(bus.a3_out), 32'(e.rd));
    check({tag, " we"}, 32'(bus.we_out), 32'(e.we));
    @(negedge clk);
    check({tag, " done_1cyc"}, 32'({bus.done, bus.we_out}), 32'd0);
    check({tag, " busy_drop"}, 32'(bus.busy), 32'd0);
    check({tag, " hold"}, bus.result, e.res);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    bus.start = 1'b0; bus.funct3 = 3'b000; bus.src_a = 32'h0; bus.src_b = 32'h0; bus.rd_in = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done_we", 32'({bus.done, bus.we_out}), 32'd0);
    check("reset_a3", 32'(bus.a3_out), 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_7x6",    F3_MUL,    32'd7,          32'd6,          5'd5, 32'd42,         1'b0, 1'b0);
    run_op("mulh_m1",    F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1, 32'h0000_0000,  1'b0, 1'b0);
    run_op("mulhu_m1",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2, 32'hFFFF_FFFE,  1'b0, 1'b0);
    run_op("mulhsu_m1",  F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3, 32'hFFFF_FFFF,  1'b0, 1'b0);
    run_op("mul_m1",     F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4, 32'h0000_0001,  1'b0, 1'b0);
    run_op("mulh_min",   F3_MULH,   32'h8000_0000,  32'h8000_0000,  5'd6, 32'h4000_0000,  1'b0, 1'b0);
    run_op("mulhu_2p16", F3_MULHU,  32'h0001_0000,  32'h0001_0000,  5'd7, 32'h0000_0001,  1'b0, 1'b0);
    run_op("div_m7_2",   F3_DIV,    32'hFFFF_FFF9,  32'd2,          5'd8, 32'hFFFF_FFFD,  1'b0, 1'b0);
    run_op("rem_m7_2",   F3_REM,    32'hFFFF_FFF9,  32'd2,          5'd9, 32'hFFFF_FFFF,  1'b0, 1'b0);
    run_op("divu_m7_2",  F3_DIVU,   32'hFFFF_FFF9,  32'd2,          5'd10, 32'h7FFF_FFFC, 1'b0, 1'b0);
    run_op("remu_m7_2",  F3_REMU,   32'hFFFF_FFF9,  32'd2,          5'd11, 32'h0000_0001, 1'b0, 1'b0);
    run_op("div_100_m7", F3_DIV,    32'd100,        32'hFFFF_FFF9,  5'd12, 32'hFFFF_FFF2, 1'b0, 1'b0);
    run_op("rem_100_m7", F3_REM,    32'd100,        32'hFFFF_FFF9,  5'd13, 32'h0000_0002, 1'b0, 1'b0);
    run_op("divu_by0",   F3_DIVU,   32'd123,        32'd0,          5'd14, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("rem_by0",    F3_REM,    32'h0000_1234,  32'd0,          5'd15, 32'h0000_1234, 1'b1, 1'b0);
    run_op("rem_ovf",    F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h0000_0000, 1'b1, 1'b0);
    run_op("div_ovf",    F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h8000_0000, 1'b1, 1'b0);
    run_op("mul_x0",     F3_MUL,    32'd3,          32'd5,          5'd0,  32'd15,        1'b0, 1'b0);
    run_op("divu_poke",  F3_DIVU,   32'd100,        32'd7,          5'd18, 32'd14,        1'b0, 1'b1);

    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
    check("poke_ignored", 32'(cnt), 32'd0);

    bus.start = 1'b1; bus.funct3 = F3_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.rd_in = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done_we", 32'({bus.done, bus.we_out}), 32'd0);
    check("abort_a3", 32'(bus.a3_out), 32'd0);
    check("abort_result", bus.result, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.we_out === 1'b1) cnt++;
      @(negedge clk);
    end
    check("abort_no_pulse", 32'(cnt), 32'd0);

    run_op("div_after_abort", F3_DIV, 32'd1000, 32'd3, 5'd21, 32'd333, 1'b0, 1'b0);
    run_op("b2b_remu",        F3_REMU, 32'd1000, 32'd3, 5'd22, 32'd1,  1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
